// File: rtl/const_op_accumulator.sv
// ---------------------------------------------------------------------------
// const_op_accumulator
//
// Pipelined constant-select add/sub unit with an internal accumulator.
// Each accepted operation combines the operand with either one of four
// parameter constants (ops 00/01) or with the accumulator (ops 10/11).
// The result is registered into a one-entry output stage with a
// valid/ready handshake. That stage can take a new result on the same
// edge as it hands off the previous one, so throughput is one result per
// cycle.
//
// Parameters:
//   WIDTH     data width of operand, result and accumulator (>= 2)
//   K0..K3    constants picked by MyConstantSelect
//   SATURATE  0 = wrap modulo 2^WIDTH, 1 = clamp (all-ones on carry,
//             zero on borrow)
//
// Ports:
//   MyClock           rising-edge clock
//   MyResetN          asynchronous active-low reset
//   MyInValid         an operation is presented
//   MyInReady         the block can accept an operation this cycle
//   MyInput           unsigned operand A
//   MyConstantSelect  selects K0..K3
//   MyOperation       00 A+K, 01 A-K, 10 ACC+=A, 11 ACC-=A
//   MyClear           synchronous accumulator clear
//   MyOutValid        MyOutput/MyOverflow hold a result
//   MyOutReady        downstream accepts the result
//   MyOutput          result
//   MyOverflow        carry (add) or borrow (sub) for this result
// ---------------------------------------------------------------------------
module const_op_accumulator #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] K0       = WIDTH'(1),
    parameter logic [WIDTH-1:0] K1       = WIDTH'(2),
    parameter logic [WIDTH-1:0] K2       = WIDTH'(4),
    parameter logic [WIDTH-1:0] K3       = WIDTH'(8),
    parameter int unsigned      SATURATE = 0
) (
    input  logic             MyClock,
    input  logic             MyResetN,
    input  logic             MyInValid,
    output logic             MyInReady,
    input  logic [WIDTH-1:0] MyInput,
    input  logic [1:0]       MyConstantSelect,
    input  logic [1:0]       MyOperation,
    input  logic             MyClear,
    output logic             MyOutValid,
    input  logic             MyOutReady,
    output logic [WIDTH-1:0] MyOutput,
    output logic             MyOverflow
);

    localparam logic [4*WIDTH-1:0] K_FLAT = {K3, K2, K1, K0};

    // Constant lookup table
    logic [WIDTH-1:0] k_table [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_k_table
            assign k_table[gi] = K_FLAT[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // State
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_ovf_reg;
    logic [WIDTH-1:0] acc_reg;

    // Datapath
    logic             accept;
    logic             op_is_acc;
    logic             op_is_sub;
    logic [WIDTH-1:0] acc_eff;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   sum_wide;
    logic [WIDTH:0]   diff_wide;
    logic [WIDTH:0]   raw_wide;
    logic             ovf_next;
    logic [WIDTH-1:0] result_next;

    // One-entry output stage: free when empty or being drained this cycle.
    assign MyInReady = !out_valid_reg || MyOutReady;
    assign accept    = MyInValid && MyInReady;

    assign op_is_acc = MyOperation[1];
    assign op_is_sub = MyOperation[0];

    // A clear on the same edge as an accumulate op takes effect first,
    // so the op sees a zero accumulator.
    assign acc_eff = MyClear ? '0 : acc_reg;

    assign lhs = op_is_acc ? acc_eff : MyInput;
    assign rhs = op_is_acc ? MyInput : k_table[MyConstantSelect];

    // One extra bit: carry out of the add, or borrow (lhs < rhs) of the sub.
    assign sum_wide  = {1'b0, lhs} + {1'b0, rhs};
    assign diff_wide = {1'b0, lhs} - {1'b0, rhs};
    assign raw_wide  = op_is_sub ? diff_wide : sum_wide;
    assign ovf_next  = raw_wide[WIDTH];

    generate
        if (SATURATE != 0) begin : g_sat
            always_comb begin
                result_next = raw_wide[WIDTH-1:0];
                if (ovf_next) begin
                    result_next = op_is_sub ? '0 : '1;
                end
            end
        end else begin : g_wrap
            assign result_next = raw_wide[WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge MyClock or negedge MyResetN) begin
        if (!MyResetN) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ovf_reg   <= 1'b0;
            acc_reg       <= '0;
        end else begin
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= result_next;
                out_ovf_reg   <= ovf_next;
            end else if (out_valid_reg && MyOutReady) begin
                // Data and flag keep their last values after hand-off
                out_valid_reg <= 1'b0;
            end

            // Clear acts regardless of the handshake; an accepted
            // accumulate op already folds the clear in via acc_eff.
            if (accept && op_is_acc) begin
                acc_reg <= result_next;
            end else if (MyClear) begin
                acc_reg <= '0;
            end
        end
    end

    assign MyOutValid = out_valid_reg;
    assign MyOutput   = out_data_reg;
    assign MyOverflow = out_ovf_reg;

endmodule

// File: tb/tb_const_op_accumulator.sv
// ---------------------------------------------------------------------------
// tb_const_op_accumulator
//
// Drives three instances from one shared stimulus stream:
//   d0: WIDTH=8,  default constants, wrapping
//   d1: WIDTH=8,  default constants, saturating
//   d2: WIDTH=12, constants 0x123/0x456/0x800/0xFFF, wrapping
// A reference model computes each result when an operation is accepted
// and pushes it to a scoreboard queue; the entry is popped when the
// output handshake completes.
// ---------------------------------------------------------------------------
module tb_const_op_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [11:0] in_data;
    logic [1:0]  sel;
    logic [1:0]  op;
    logic        clr;
    logic        out_ready;

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic [7:0]  dout0, dout1;
    logic [11:0] dout2;
    logic        ovf0, ovf1, ovf2;

    int n_cmp = 0;
    int n_err = 0;

    const_op_accumulator u_d0 (
        .MyClock(clk), .MyResetN(rst_n), .MyInValid(in_valid), .MyInReady(rdy0),
        .MyInput(in_data[7:0]), .MyConstantSelect(sel), .MyOperation(op),
        .MyClear(clr), .MyOutValid(vld0), .MyOutReady(out_ready),
        .MyOutput(dout0), .MyOverflow(ovf0)
    );

    const_op_accumulator #(.SATURATE(1)) u_d1 (
        .MyClock(clk), .MyResetN(rst_n), .MyInValid(in_valid), .MyInReady(rdy1),
        .MyInput(in_data[7:0]), .MyConstantSelect(sel), .MyOperation(op),
        .MyClear(clr), .MyOutValid(vld1), .MyOutReady(out_ready),
        .MyOutput(dout1), .MyOverflow(ovf1)
    );

    const_op_accumulator #(
        .WIDTH(12), .K0(12'h123), .K1(12'h456), .K2(12'h800), .K3(12'hFFF),
        .SATURATE(0)
    ) u_d2 (
        .MyClock(clk), .MyResetN(rst_n), .MyInValid(in_valid), .MyInReady(rdy2),
        .MyInput(in_data), .MyConstantSelect(sel), .MyOperation(op),
        .MyClear(clr), .MyOutValid(vld2), .MyOutReady(out_ready),
        .MyOutput(dout2), .MyOverflow(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed {overflow, result} per instance
    logic [12:0] obs [3];
    logic        obs_vld [3];
    logic        obs_rdy [3];
    always_comb begin
        obs[0]     = {ovf0, 4'h0, dout0};
        obs[1]     = {ovf1, 4'h0, dout1};
        obs[2]     = {ovf2, dout2};
        obs_vld[0] = vld0;
        obs_vld[1] = vld1;
        obs_vld[2] = vld2;
        obs_rdy[0] = rdy0;
        obs_rdy[1] = rdy1;
        obs_rdy[2] = rdy2;
    end

    // Reference model configuration and state
    int cfg_w   [3]    = '{8, 8, 12};
    int cfg_sat [3]    = '{0, 1, 0};
    int cfg_k   [3][4] = '{'{1, 2, 4, 8}, '{1, 2, 4, 8}, '{'h123, 'h456, 'h800, 'hFFF}};
    int          m_acc  [3];
    logic [12:0] m_last [3];
    bit          m_valid;
    logic [2:0][12:0] sbq [$];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [12:0] model_op(input int w, input int sat, input int k,
                                             input int a_in, input int opc, input int acc_in,
                                             output int acc_out);
        int mask;
        int a;
        int lhs;
        int rhs;
        int r;
        bit ov;
        mask = (1 << w) - 1;
        a    = a_in & mask;
        if (opc >= 2) begin
            lhs = acc_in;
            rhs = a;
        end else begin
            lhs = a;
            rhs = k;
        end
        if (opc % 2 == 0) begin
            r  = lhs + rhs;
            ov = (r > mask);
        end else begin
            ov = (lhs < rhs);
            r  = lhs - rhs;
        end
        r = r & mask;
        if (sat != 0 && ov) r = (opc % 2 == 0) ? mask : 0;
        acc_out = (opc >= 2) ? r : acc_in;
        return {ov, r[11:0]};
    endfunction

    // One clock: check outputs at the falling edge, advance the model,
    // then let the rising edge happen and return just after it.
    task automatic step();
        bit m_ready;
        bit accept;
        bit transfer;
        logic [2:0][12:0] entry;
        logic [12:0] expv;
        int acc_new;
        @(negedge clk);
        m_ready = !m_valid || out_ready;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_in_ready", i), 32'(obs_rdy[i]), 32'(m_ready));
            chk($sformatf("d%0d_out_valid", i), 32'(obs_vld[i]), 32'(m_valid));
            expv = m_last[i];
            if (m_valid) begin
                if (sbq.size() == 0) begin
                    chk("sbq_underflow", 32'(sbq.size()), 32'd1);
                end else begin
                    expv = sbq[0][i];
                end
            end
            chk($sformatf("d%0d_result", i), 32'(obs[i]), 32'(expv));
        end
        $display("t=%0t vld=%0b a=%0d sel=%0d op=%0d clr=%0b ordy=%0b | d0=%0d/%0b d1=%0d/%0b d2=%0d/%0b v=%0b",
                 $time, in_valid, in_data, sel, op, clr, out_ready,
                 dout0, ovf0, dout1, ovf1, dout2, ovf2, vld0);
        accept   = in_valid && m_ready;
        transfer = m_valid && out_ready;
        for (int i = 0; i < 3; i++) begin
            if (clr) m_acc[i] = 0;
            entry[i] = model_op(cfg_w[i], cfg_sat[i], cfg_k[i][sel], int'(in_data),
                                int'(op), m_acc[i], acc_new);
            if (accept) begin
                m_acc[i]  = acc_new;
                m_last[i] = entry[i];
            end
        end
        if (transfer) void'(sbq.pop_front());
        if (accept) sbq.push_back(entry);
        m_valid = accept || (m_valid && !out_ready);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int a, input int s, input int o,
                         input bit c, input bit r);
        in_valid  = v;
        in_data   = 12'(a);
        sel       = 2'(s);
        op        = 2'(o);
        clr       = c;
        out_ready = r;
        step();
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        sbq.delete();
        for (int i = 0; i < 3; i++) begin
            m_acc[i]  = 0;
            m_last[i] = '0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; sel = '0; op = '0; clr = 1'b0; out_ready = 1'b1;
        model_reset();
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rst_valid", i), 32'(obs_vld[i]), 32'd0);
            chk($sformatf("d%0d_rst_result", i), 32'(obs[i]), 32'd0);
            chk($sformatf("d%0d_rst_ready", i), 32'(obs_rdy[i]), 32'd1);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic constant add / carry / borrow
        drive(1, 5,   1, 0, 0, 1);
        drive(1, 250, 3, 0, 0, 1);
        drive(1, 3,   2, 1, 0, 1);
        // Accumulate with wrap / saturation, then clear + subtract together
        drive(1, 100, 0, 2, 0, 1);
        drive(1, 100, 0, 2, 0, 1);
        drive(1, 100, 0, 2, 0, 1);
        drive(1, 1,   0, 3, 1, 1);
        drive(0, 0,   0, 0, 0, 1);
        drive(0, 0,   0, 0, 0, 1);

        // Backpressure: one result then five stalled cycles with extra requests
        drive(1, 7, 0, 2, 0, 0);
        for (int n = 0; n < 5; n++) drive(1, 50, 1, 2, 0, 0);
        drive(1, 1, 0, 2, 0, 1);   // transfer and accept on the same edge
        drive(0, 0, 0, 0, 0, 1);

        // Asynchronous reset while a result is stalled
        drive(1, 20, 0, 2, 0, 0);
        drive(0, 0,  0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_async_rst_valid", i), 32'(obs_vld[i]), 32'd0);
            chk($sformatf("d%0d_async_rst_result", i), 32'(obs[i]), 32'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 9, 0, 2, 0, 1);
        drive(0, 0, 0, 0, 0, 1);

        // Constant sweep, then the 12-bit carry at 4096
        for (int s = 0; s < 4; s++) drive(1, 0, s, 0, 0, 1);
        drive(1, 1, 3, 0, 0, 1);
        drive(1, 4095, 0, 3, 0, 1);

        // Random mix of ops, clears and backpressure
        for (int n = 0; n < 60; n++) begin
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 4095)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 3) != 0));
        end

        // Drain
        for (int n = 0; n < 3; n++) drive(0, 0, 0, 0, 0, 1);
        chk("sbq_empty", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/const_op_accumulator.md
Name: const_op_accumulator

Overview:
- Parametrised, pipelined successor to the 8-bit constant-select add/sub unit.
- Combines the input with one of four parameter constants, or with an internal accumulator.
- Registers the result behind a valid/ready output handshake with overflow flag and optional saturation.
- Sits between the lab's stimulus/switch interface and the display/output logic.

Parameters:
- WIDTH, 8, data width of MyInput, MyOutput and accumulator (>= 2).
- K0, 1, constant selected by MyConstantSelect = 0 (WIDTH bits, unsigned).
- K1, 2, constant for select = 1.
- K2, 4, constant for select = 2.
- K3, 8, constant for select = 3.
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp to 2^WIDTH-1 on carry, 0 on borrow.

Ports:
- MyClock  in  1  rising-edge clock.
- MyResetN  in  1  asynchronous active-low reset.
- MyInValid  in  1  input operation present.
- MyInReady  out  1  block can accept an operation this cycle.
- MyInput  in  WIDTH  unsigned operand A.
- MyConstantSelect  in  2  selects K0..K3.
- MyOperation  in  2  00 A+K, 01 A-K, 10 ACC+=A, 11 ACC-=A.
- MyClear  in  1  synchronous accumulator clear.
- MyOutValid  out  1  MyOutput/MyOverflow hold a result.
- MyOutReady  in  1  downstream accepts result.
- MyOutput  out  WIDTH  result.
- MyOverflow  out  1  carry (add) or borrow (sub) occurred for this result.

Behaviour:
- Reset (MyResetN low, asynchronous): MyOutValid=0, MyOutput=0, MyOverflow=0, ACC=0. MyInReady=1 immediately after reset.
- MyInReady = !MyOutValid || MyOutReady (combinational; one-entry output register, full throughput).
- Accept: MyInValid && MyInReady at a rising edge. Result is registered on that edge, so latency is 1 cycle. MyOutValid=1 the following cycle.
- Output transfer: MyOutValid && MyOutReady.
  - Transfer with no accept in the same cycle: MyOutValid drops to 0 next cycle. MyOutput and MyOverflow hold their last values.
  - Simultaneous transfer and accept: the new result replaces the old one and MyOutValid stays 1.
- Stall rule: while MyOutValid && !MyOutReady, MyOutput, MyOverflow and ACC hold.
- Arithmetic is computed at WIDTH+1 bits, unsigned. K = K[MyConstantSelect].
  - Op 00: R = A+K; overflow = bit WIDTH (carry).
  - Op 01: R = A-K; overflow = (A < K).
  - Op 10: R = ACC+A; overflow = carry. ACC <= R (post-saturation).
  - Op 11: R = ACC-A; overflow = (ACC < A). ACC <= R.
  - Ops 00/01 never modify ACC.
- SATURATE=1: on overflow, add ops give all-ones and sub ops give 0. MyOverflow is still asserted.
- SATURATE=0: result wraps modulo 2^WIDTH.
- MyClear: at a rising edge, ACC <= 0 independent of the handshake. No output result is produced. It does not affect MyOutValid or MyOutput.
- MyClear together with an accepted op 10/11: clear applies first, so the op uses ACC=0 (R = 0+A, or 0-A with borrow when A != 0).
- MyInValid low, or not accepted: no state change except MyClear and output transfer.
- Reset mid-stall: the pending result is discarded and ACC=0.
- No X propagation: all outputs are driven from registers or from reset-defined logic.

Test Plan:
- Reset then WIDTH=8, A=5, sel=1, op=00, MyOutReady=1 -> one cycle later MyOutValid=1, MyOutput=7, MyOverflow=0.
- A=250, sel=3, op=00: SATURATE=0 -> MyOutput=2, MyOverflow=1. SATURATE=1 -> MyOutput=255, MyOverflow=1. Then A=3, sel=2, op=01 -> MyOutput=0 (SAT=1) or 255 (SAT=0), MyOverflow=1.
- Accumulate A=100, 100, 100 with op=10, back-to-back, MyOutReady=1 -> outputs 100, 200, 44 with overflow 0, 0, 1 (SAT=0). Then MyClear plus op=11 with A=1 in the same cycle -> MyOutput=255, MyOverflow=1, ACC=255.
- Backpressure: hold MyOutReady=0 after one accepted result -> MyInReady=0, MyOutput and ACC stable for 5 cycles, extra MyInValid ignored. Raise MyOutReady with MyInValid=1 -> transfer and new accept in the same cycle, MyOutValid stays 1.
- Assert MyResetN low asynchronously mid-stall, between clock edges -> MyOutValid=0, MyOutput=0 immediately. The next accumulate with A=9 yields 9.
- Sweep all four selects with A=0 and op=00 -> outputs K0..K3 = 1, 2, 4, 8. Override K0..K3 and WIDTH=12 -> matching values, with the carry asserted at 4096.
